bank_cmd_arbiter: RTL and testbench
===================================

# bank_cmd_arbiter

Round-robin command scheduler sitting between the per-bank machines and the single DRAM command port of the controller. Each cycle it selects one eligible bank command, accepts it via that bank's `cmd_ready`, and registers it into a one-entry output stage toward the PHY command multiplexer. Eligibility enforces the inter-bank constraints a single bank machine cannot see: activate-to-activate spacing (tRRD), the four-activate window (tFAW), write-to-read turnaround (tWTR) and read-to-write turnaround (tRTW).

## Interface
- `NBANKS`, default 8: number of bank machines; power of two, 2..16.
- `ABITS`, default 17: command address width.
- `BABITS`, default `$clog2(NBANKS)`: bank address width.
- `sys_clk`  in  1  sole clock; all logic is rising-edge.
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
- `bm_cmd_valid`  in  NBANKS  per-bank command valid.
- `bm_cmd_ready`  out  NBANKS  per-bank accept; at most one bit high per cycle.
- `bm_cmd_a`  in  NBANKS*ABITS  per-bank address; bank i occupies slice [i*ABITS +: ABITS].
- `bm_cmd_cas`, `bm_cmd_ras`, `bm_cmd_we`, `bm_cmd_is_cmd`, `bm_cmd_is_read`, `bm_cmd_is_write`  in  NBANKS each  per-bank command flags.
- `out_valid`  out  1  registered command valid.
- `out_ready`  in  1  downstream accept.
- `out_a`  out  ABITS  registered address.
- `out_ba`  out  BABITS  index of the granting bank.
- `out_cas`, `out_ras`, `out_we`, `out_is_cmd`, `out_is_read`, `out_is_write`  out  1 each  registered flags.
- `cfg_tRRD`, `cfg_tFAW`, `cfg_tWTR`, `cfg_tRTW`  in  8 each  spacings in sys_clk cycles, quasi-static.

## Operation
- Classification per bank request:
  - ACT = `ras & ~cas & ~we`.
  - PRE = `ras & we & ~cas`.
  - RD = `is_read`.
  - WR = `is_write`.
  - Anything else with valid high is treated as PRE-class: always eligible.
- Eligible bank: `bm_cmd_valid[i]` high and the constraint for its class is satisfied:
  - ACT needs `rrd_ok & faw_ok`.
  - RD needs `wtr_ok`.
  - WR needs `rtw_ok`.
  - PRE needs nothing.
- Stage accept: `load = ~out_valid | out_ready`.
- When `load` is high and any bank is eligible:
  - The winner is the first eligible index strictly after `rr_ptr`, searching cyclically modulo NBANKS.
  - `bm_cmd_ready[winner]` is asserted combinationally in the same cycle.
  - The winner's fields and `out_ba = winner` are registered.
  - `rr_ptr` takes the value `winner`.
- No eligible bank with `load` high: `out_valid` clears at the next edge.
- `bm_cmd_ready` is never asserted while `load` is low, so the output stage never overwrites an unconsumed command.
- Spacing counters (8-bit down-counters) are updated when a command is accepted from a bank, not when it leaves the output stage:
  - Load value is `cfg-1` when cfg ≥ 2, else 0.
  - `ok` = count == 0.
  - Decrement when nonzero.
  - A load in the same cycle as a decrement takes priority over the decrement.
- Counter triggers:
  - rrd counter loads on an accepted ACT.
  - wtr counter loads on an accepted WR.
  - rtw counter loads on an accepted RD.

## Timing
- Reset values:
  - `out_valid` = 0.
  - All `out_*` fields = 0.
  - `rr_ptr` = NBANKS-1, so bank 0 wins first.
  - All counters = 0, so all `*_ok` are high.
  - `faw_idx` = 0.
- `bm_cmd_ready` is combinational and is 0 throughout reset.
- Latency: a command accepted from a bank in cycle n appears on `out_valid` in cycle n+1.
- Throughput: with `out_ready` held high, one command per cycle.
- Output stability: while `out_valid & ~out_ready`, all `out_*` signals hold stable.
- With cfg = N ≥ 2, the next same-class-constrained command is accepted no earlier than N cycles after the trigger.
- Reset asserted mid-operation:
  - Outputs clear asynchronously.
  - An in-flight output command is dropped; bank machines re-present it, because their accept never completed downstream.

## Configuration
- `BANK_ARB_TFAW_EN` defined:
  - Four tFAW down-counters arranged as a ring, with `faw_idx` pointing at the oldest entry.
  - `faw_ok` = counter[faw_idx] == 0.
  - An accepted ACT loads counter[faw_idx] using the standard load rule with `cfg_tFAW`, then advances `faw_idx` modulo 4.
- `BANK_ARB_TFAW_EN` undefined:
  - `faw_ok` is tied to 1.
  - `cfg_tFAW` is ignored.
  - No ring hardware is generated.

## Structure
- Shared package `bank_arb_pkg` holds:
  - `cmd_class_t` enum {ACT, PRE, RD, WR}.
  - The classification function.
  - Counter width constant `TCNT_W = 8`.
- Sub-module `timing_down_counter`, instanced for rrd, wtr, rtw and each of the four tFAW entries:
  - Ports: `sys_clk`, `sys_rst_n`, `load`, `cfg[7:0]`, `ok`.
  - Implements the load/decrement rule above.
- Round-robin selection is a combinational function inside the top module.

## Test plan
- Reads on banks 0 and 1 held valid, `out_ready`=1 → grants 0,1,0,1 on consecutive cycles; `out_ba` follows one cycle later.
- `cfg_tRRD`=4, ACTs on banks 2 and 3 presented together → bank 2 accepted at cycle t, bank 3 at t+4.
- `BANK_ARB_TFAW_EN` defined, `cfg_tRRD`=1, `cfg_tFAW`=20, five ACTs on banks 0–4 → first four accepted back-to-back from t, fifth at t+20. Same stimulus undefined → all five back-to-back.
- WR on bank 1 at t, `cfg_tWTR`=6, RD on bank 4 plus PRE on bank 5 pending → PRE accepted at t+1, RD at t+6.
- `out_ready` low for 3 cycles with commands pending → `out_*` stable, `bm_cmd_ready` all 0, `rr_ptr` unchanged.
- `sys_rst_n` pulsed low while `out_valid`=1 with counters loaded → `out_valid` drops immediately; after release, the first grant goes to the lowest eligible bank with no spacing stall.

Source files
------------

// File: rtl/bank_arb_pkg.sv
// Shared types and helpers for the bank command arbiter: command classes,
// the per-request classifier and the spacing-counter load rule.
package bank_arb_pkg;

   localparam int TCNT_W = 8;

   typedef enum logic [1:0] {
      ACT,
      PRE,
      RD,
      WR
   } cmd_class_t;

   // Anything that is not an activate, precharge, read or write is always eligible,
   // so it is folded into the PRE class.
   function automatic cmd_class_t classify(
      input logic cas,
      input logic ras,
      input logic we,
      input logic is_read,
      input logic is_write
   );
      if (ras & ~cas & ~we)      return ACT;
      else if (ras & we & ~cas)  return PRE;
      else if (is_read)          return RD;
      else if (is_write)         return WR;
      return PRE;
   endfunction

   function automatic logic [TCNT_W-1:0] tcnt_load(input logic [TCNT_W-1:0] cfg);
      return (cfg >= TCNT_W'(2)) ? (cfg - TCNT_W'(1)) : '0;
   endfunction

endpackage

// File: rtl/timing_down_counter.sv
// Inter-bank spacing counter: reloads on a trigger, counts down to zero,
// and reports ok while the count is zero.
module timing_down_counter
   import bank_arb_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              load,
   input  logic [TCNT_W-1:0] cfg,
   output logic              ok
);

   logic [TCNT_W-1:0] count;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= tcnt_load(cfg);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign ok = (count == '0);

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Round-robin DRAM command scheduler with tRRD/tWTR/tRTW spacing and an optional
// four-activate window ring enabled by defining BANK_ARB_TFAW_EN.
module bank_cmd_arbiter
   import bank_arb_pkg::*;
#(
   parameter int NBANKS = 8,
   parameter int ABITS  = 17,
   parameter int BABITS = $clog2(NBANKS)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [NBANKS-1:0]       bm_cmd_valid,
   output logic [NBANKS-1:0]       bm_cmd_ready,
   input  logic [NBANKS*ABITS-1:0] bm_cmd_a,
   input  logic [NBANKS-1:0]       bm_cmd_cas,
   input  logic [NBANKS-1:0]       bm_cmd_ras,
   input  logic [NBANKS-1:0]       bm_cmd_we,
   input  logic [NBANKS-1:0]       bm_cmd_is_cmd,
   input  logic [NBANKS-1:0]       bm_cmd_is_read,
   input  logic [NBANKS-1:0]       bm_cmd_is_write,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ABITS-1:0]        out_a,
   output logic [BABITS-1:0]       out_ba,
   output logic                    out_cas,
   output logic                    out_ras,
   output logic                    out_we,
   output logic                    out_is_cmd,
   output logic                    out_is_read,
   output logic                    out_is_write,
   input  logic [7:0]              cfg_tRRD,
   input  logic [7:0]              cfg_tFAW,
   input  logic [7:0]              cfg_tWTR,
   input  logic [7:0]              cfg_tRTW
);

   // First requester strictly after ptr, cyclically; MSB of the result flags a hit.
   function automatic logic [BABITS:0] rr_pick(
      input logic [NBANKS-1:0] req,
      input logic [BABITS-1:0] ptr
   );
      logic [BABITS:0]   res;
      logic [BABITS-1:0] idx;
      res = '0;
      for (int k = NBANKS; k >= 1; k--) begin
         idx = ptr + BABITS'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   logic              rrd_ok, faw_ok, wtr_ok, rtw_ok;
   logic [NBANKS-1:0] elig;
   logic [BABITS-1:0] rr_ptr;
   logic [BABITS-1:0] winner;
   logic              found;
   logic              load;
   logic              grant;
   cmd_class_t        win_cls;
   logic [ABITS-1:0]  win_a;
   logic              act_acc, rd_acc, wr_acc;

   for (genvar i = 0; i < NBANKS; i++) begin : g_elig
      cmd_class_t cls;
      assign cls = classify(bm_cmd_cas[i], bm_cmd_ras[i], bm_cmd_we[i],
                            bm_cmd_is_read[i], bm_cmd_is_write[i]);
      assign elig[i] = bm_cmd_valid[i] &
                       ((cls == ACT) ? (rrd_ok & faw_ok) :
                        (cls == RD)  ? wtr_ok :
                        (cls == WR)  ? rtw_ok : 1'b1);
   end

   assign {found, winner} = rr_pick(elig, rr_ptr);
   assign load  = ~out_valid | out_ready;
   // Gated by reset so no bank sees an accept while the stage is held cleared.
   assign grant = sys_rst_n & load & found;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      bm_cmd_ready = '0;
      if (grant) bm_cmd_ready[winner] = 1'b1;
   end

   assign win_a   = bm_cmd_a[int'(winner)*ABITS +: ABITS];
   assign win_cls = classify(bm_cmd_cas[winner], bm_cmd_ras[winner], bm_cmd_we[winner],
                             bm_cmd_is_read[winner], bm_cmd_is_write[winner]);

   // Spacing is measured from acceptance at the bank, not departure from the stage.
   assign act_acc = grant & (win_cls == ACT);
   assign rd_acc  = grant & (win_cls == RD);
   assign wr_acc  = grant & (win_cls == WR);

   timing_down_counter u_rrd (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (act_acc),
      .cfg       (cfg_tRRD),
      .ok        (rrd_ok)
   );

   timing_down_counter u_wtr (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (wr_acc),
      .cfg       (cfg_tWTR),
      .ok        (wtr_ok)
   );

   timing_down_counter u_rtw (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (rd_acc),
      .cfg       (cfg_tRTW),
      .ok        (rtw_ok)
   );

`ifdef BANK_ARB_TFAW_EN
   logic [1:0] faw_idx;
   logic [3:0] faw_ok_vec;

   // Ring of four windows; faw_idx points at the oldest activate.
   for (genvar j = 0; j < 4; j++) begin : g_faw
      timing_down_counter u_faw (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .load      (act_acc & (faw_idx == 2'(j))),
         .cfg       (cfg_tFAW),
         .ok        (faw_ok_vec[j])
      );
   end

   assign faw_ok = faw_ok_vec[faw_idx];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         faw_idx <= '0;
      end else if (act_acc) begin
         faw_idx <= faw_idx + 2'd1;
      end
   end
`else
   logic unused_tfaw;
   assign unused_tfaw = ^cfg_tFAW;
   assign faw_ok      = 1'b1;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_valid    <= 1'b0;
         out_a        <= '0;
         out_ba       <= '0;
         out_cas      <= 1'b0;
         out_ras      <= 1'b0;
         out_we       <= 1'b0;
         out_is_cmd   <= 1'b0;
         out_is_read  <= 1'b0;
         out_is_write <= 1'b0;
         rr_ptr       <= BABITS'(NBANKS - 1);
      end else if (load) begin
         out_valid <= grant;
         if (grant) begin
            out_a        <= win_a;
            out_ba       <= winner;
            out_cas      <= bm_cmd_cas[winner];
            out_ras      <= bm_cmd_ras[winner];
            out_we       <= bm_cmd_we[winner];
            out_is_cmd   <= bm_cmd_is_cmd[winner];
            out_is_read  <= bm_cmd_is_read[winner];
            out_is_write <= bm_cmd_is_write[winner];
            rr_ptr       <= winner;
         end
      end
   end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed scoreboard bench for bank_cmd_arbiter: round-robin order, spacing
// constraints, output stall and mid-operation reset.
module tb_bank_cmd_arbiter;

   localparam int NB = 8;
   localparam int AB = 17;
   localparam int BB = 3;

   typedef enum {K_ACT, K_PRE, K_RD, K_WR} kind_t;

   typedef struct {
      int            cyc;
      logic [BB-1:0] ba;
      logic [AB-1:0] a;
      logic [5:0]    fl;
   } exp_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic [NB-1:0]    valid, ready, cas, ras, we, is_cmd, is_rd, is_wr;
   logic [NB*AB-1:0] addr;
   logic             out_valid, out_ready;
   logic [AB-1:0]    out_a;
   logic [BB-1:0]    out_ba;
   logic             out_cas, out_ras, out_we, out_is_cmd, out_is_read, out_is_write;
   logic [7:0]       cfg_trrd, cfg_tfaw, cfg_twtr, cfg_trtw;
   logic [5:0]       out_fl;

   int               errors = 0;
   int               checks = 0;
   int               cyc = 0;
   int               c;
   logic [NB-1:0]    sticky;
   exp_t             sb[$];

   logic [NB-1:0]    s_ready;
   logic             s_ov;
   logic [BB-1:0]    s_ba;
   logic [AB-1:0]    s_a;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   assign out_fl = {out_cas, out_ras, out_we, out_is_cmd, out_is_read, out_is_write};

   bank_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BB)) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .bm_cmd_valid    (valid),
      .bm_cmd_ready    (ready),
      .bm_cmd_a        (addr),
      .bm_cmd_cas      (cas),
      .bm_cmd_ras      (ras),
      .bm_cmd_we       (we),
      .bm_cmd_is_cmd   (is_cmd),
      .bm_cmd_is_read  (is_rd),
      .bm_cmd_is_write (is_wr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_a           (out_a),
      .out_ba          (out_ba),
      .out_cas         (out_cas),
      .out_ras         (out_ras),
      .out_we          (out_we),
      .out_is_cmd      (out_is_cmd),
      .out_is_read     (out_is_read),
      .out_is_write    (out_is_write),
      .cfg_tRRD        (cfg_trrd),
      .cfg_tFAW        (cfg_tfaw),
      .cfg_tWTR        (cfg_twtr),
      .cfg_tRTW        (cfg_trtw)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_bank(input int b, input kind_t k, input logic [AB-1:0] a, input bit stick);
      valid[b]          = 1'b1;
      sticky[b]         = stick;
      addr[b*AB +: AB]  = a;
      is_cmd[b]         = 1'b1;
      {ras[b], cas[b], we[b], is_rd[b], is_wr[b]} = 5'b0;
      case (k)
         K_ACT: ras[b] = 1'b1;
         K_PRE: begin ras[b] = 1'b1; we[b] = 1'b1; end
         K_RD:  begin cas[b] = 1'b1; is_rd[b] = 1'b1; end
         K_WR:  begin cas[b] = 1'b1; we[b] = 1'b1; is_wr[b] = 1'b1; end
         default: ;
      endcase
   endtask

   // Expected command from bank b, leaving the stage at cycle oc.
   task automatic expect_out(input int b, input int oc);
      exp_t e;
      e.cyc = oc;
      e.ba  = BB'(b);
      e.a   = addr[b*AB +: AB];
      e.fl  = {cas[b], ras[b], we[b], is_cmd[b], is_rd[b], is_wr[b]};
      sb.push_back(e);
   endtask

   // One clock: sample at the falling edge, retire consumed output against the
   // scoreboard, then let accepted banks drop their request after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge sys_clk);
      s_ready = ready;
      s_ov    = out_valid;
      s_ba    = out_ba;
      s_a     = out_a;
      check("ready_onehot0", 32'($onehot0(ready)), 32'd1);
      if (out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_out observed ba=%0d a=%0h at cyc %0d, expected no command", out_ba, out_a, cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_cyc", cyc, e.cyc);
            check("out_ba", out_ba, e.ba);
            check("out_a", out_a, e.a);
            check("out_flags", out_fl, e.fl);
         end
      end
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NB; i++)
         if (s_ready[i] && !sticky[i]) valid[i] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      valid = '0; sticky = '0; cas = '0; ras = '0; we = '0;
      is_cmd = '0; is_rd = '0; is_wr = '0; addr = '0;
      out_ready = 1'b0;
      cfg_trrd = 8'd0; cfg_tfaw = 8'd0; cfg_twtr = 8'd0; cfg_trtw = 8'd0;

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ba", out_ba, 0);
      check("rst_out_a", out_a, 0);
      check("rst_out_flags", out_fl, 0);
      check("rst_rr_ptr", dut.rr_ptr, 7);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Two reads held valid alternate 0,1,0,1
      out_ready = 1'b1;
      set_bank(0, K_RD, 17'h00100, 1'b1);
      set_bank(1, K_RD, 17'h00111, 1'b1);
      c = cyc;
      expect_out(0, c + 1);
      expect_out(1, c + 2);
      expect_out(0, c + 3);
      expect_out(1, c + 4);
      repeat (4) tick();
      valid = '0;
      sticky = '0;
      repeat (3) tick();

      // tRRD = 4: second activate waits four cycles
      cfg_trrd = 8'd4;
      set_bank(2, K_ACT, 17'h00222, 1'b0);
      set_bank(3, K_ACT, 17'h00333, 1'b0);
      c = cyc;
      expect_out(2, c + 1);
      expect_out(3, c + 5);
      repeat (10) tick();

      // Five activates, tRRD off, tFAW = 20; pointer sits at 3 so bank 4 leads
      cfg_trrd = 8'd1;
      cfg_tfaw = 8'd20;
      for (int i = 0; i < 5; i++) set_bank(i, K_ACT, 17'h00400 + 17'(i), 1'b0);
      c = cyc;
      expect_out(4, c + 1);
      expect_out(0, c + 2);
      expect_out(1, c + 3);
      expect_out(2, c + 4);
`ifdef BANK_ARB_TFAW_EN
      expect_out(3, c + 21);
`else
      expect_out(3, c + 5);
`endif
      repeat (26) tick();

      // Write-to-read turnaround, with a precharge slipping past the blocked read
      cfg_twtr = 8'd6;
      cfg_trtw = 8'd3;
      set_bank(1, K_WR, 17'h00511, 1'b0);
      c = cyc;
      expect_out(1, c + 1);
      tick();
      set_bank(4, K_RD, 17'h00544, 1'b0);
      set_bank(5, K_PRE, 17'h00555, 1'b0);
      expect_out(5, c + 2);
      expect_out(4, c + 7);
      repeat (6) tick();
      // Read-to-write turnaround from the read accepted at c+6
      set_bank(6, K_WR, 17'h00566, 1'b0);
      expect_out(6, c + 10);
      repeat (6) tick();

      // Output stall: stage holds, no accepts, pointer frozen
      out_ready = 1'b1;
      set_bank(2, K_PRE, 17'h00622, 1'b0);
      set_bank(6, K_PRE, 17'h00666, 1'b0);
      c = cyc;
      tick();
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         check("stall_ready", s_ready, 0);
         check("stall_ov", s_ov, 1);
         check("stall_ba", s_ba, 2);
         check("stall_a", s_a, 17'h00622);
         check("stall_rr_ptr", dut.rr_ptr, 2);
      end
      out_ready = 1'b1;
      expect_out(2, c + 4);
      expect_out(6, c + 5);
      repeat (4) tick();

      // Reset during a held command with tRRD loaded
      cfg_trrd = 8'd10;
      out_ready = 1'b0;
      set_bank(3, K_ACT, 17'h00733, 1'b0);
      tick();
      check("hold_ov", out_valid, 1);
      check("hold_ba", out_ba, 3);
      sys_rst_n = 1'b0;
      set_bank(3, K_ACT, 17'h00733, 1'b0);
      #1;
      check("arst_ov", out_valid, 0);
      check("arst_ba", out_ba, 0);
      check("arst_a", out_a, 0);
      check("arst_ready", ready, 0);
      @(negedge sys_clk);
      valid = '0;
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      check("post_rst_ov", out_valid, 0);
      out_ready = 1'b1;
      set_bank(3, K_ACT, 17'h00733, 1'b0);
      set_bank(5, K_ACT, 17'h00755, 1'b0);
      c = cyc;
      expect_out(3, c + 1);
      expect_out(5, c + 11);
      repeat (14) tick();

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
